// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Program counter for the 2A03 datapath. A single counter with
//                carry/borrow across the full address: increment, decrement,
//                byte/full loads, vector load, and a two-step relative branch
//                (low byte first, then a page-crossing fix-up of the high byte).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int                       LO_W      = 8,
    parameter int                       HI_W      = 8,
    parameter logic [LO_W+HI_W-1:0]     RESET_VAL = 16'hFFFC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  cmd,
    input  logic [LO_W-1:0]             l_data,
    input  logic [HI_W-1:0]             h_data,
    input  logic [LO_W-1:0]             offset,
    output logic                        ready,
    output logic [LO_W+HI_W-1:0]        pc_out,
    output logic [LO_W-1:0]             l_out,
    output logic [HI_W-1:0]             h_out,
    output logic                        page_cross,
    output logic                        wrap
);

    localparam int PC_W = LO_W + HI_W;

    localparam logic [2:0] C_CMD_HOLD     = 3'd0;
    localparam logic [2:0] C_CMD_INC      = 3'd1;
    localparam logic [2:0] C_CMD_DEC      = 3'd2;
    localparam logic [2:0] C_CMD_LOAD_L   = 3'd3;
    localparam logic [2:0] C_CMD_LOAD_H   = 3'd4;
    localparam logic [2:0] C_CMD_LOAD_ALL = 3'd5;
    localparam logic [2:0] C_CMD_BRANCH   = 3'd6;
    localparam logic [2:0] C_CMD_VEC      = 3'd7;

    localparam logic [PC_W-1:0] C_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [HI_W-1:0] C_HI_ONE = {{(HI_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FIX  = 1'b1
    } state_t;

    state_t            r_state;
    logic [LO_W-1:0]   r_pcl;
    logic [HI_W-1:0]   r_pch;
    logic              r_adj_dec;      // pending fix-up direction: 1 = PCH-1, 0 = PCH+1
    logic              r_page_cross;
    logic              r_wrap;

    logic [PC_W-1:0]   w_pc;
    logic [LO_W:0]     w_br_sum;
    logic              w_adj_up;
    logic              w_adj_dn;

    assign w_pc     = {r_pch, r_pcl};
    assign w_br_sum = {1'b0, r_pcl} + {1'b0, offset};
    // Forward offset that carried out needs PCH+1; backward offset that did
    // not carry (i.e. borrowed) needs PCH-1.
    assign w_adj_up = ~offset[LO_W-1] &  w_br_sum[LO_W];
    assign w_adj_dn =  offset[LO_W-1] & ~w_br_sum[LO_W];

    assign ready      = (r_state == ST_IDLE);
    assign pc_out     = w_pc;
    assign l_out      = r_pcl;
    assign h_out      = r_pch;
    assign page_cross = r_page_cross;
    assign wrap       = r_wrap;

    // Command execution and branch fix-up state machine; event pulses default low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            {r_pch, r_pcl} <= RESET_VAL;
            r_adj_dec    <= 1'b0;
            r_page_cross <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_page_cross <= 1'b0;
            r_wrap       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    case (cmd)
                        C_CMD_HOLD: ;
                        C_CMD_INC: begin
                            {r_pch, r_pcl} <= w_pc + C_PC_ONE;
                            r_wrap         <= &w_pc;
                        end
                        C_CMD_DEC: begin
                            {r_pch, r_pcl} <= w_pc - C_PC_ONE;
                            r_wrap         <= ~|w_pc;
                        end
                        C_CMD_LOAD_L:   r_pcl <= l_data;
                        C_CMD_LOAD_H:   r_pch <= h_data;
                        C_CMD_LOAD_ALL: {r_pch, r_pcl} <= {h_data, l_data};
                        C_CMD_BRANCH: begin
                            r_pcl <= w_br_sum[LO_W-1:0];
                            if (w_adj_up || w_adj_dn) begin
                                r_adj_dec <= w_adj_dn;
                                r_state   <= ST_FIX;
                            end
                        end
                        C_CMD_VEC:      {r_pch, r_pcl} <= RESET_VAL;
                        default: ;
                    endcase
                end
                ST_FIX: begin
                    // Commands are ignored here; PCH wrap is not a full-address wrap.
                    r_pch        <= r_adj_dec ? (r_pch - C_HI_ONE) : (r_pch + C_HI_ONE);
                    r_page_cross <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
